llsc_reservation_unit: RTL and testbench
========================================

Name: llsc_reservation_unit

Overview:
- Parametrised successor to the single LLbit register: tracks one LL/SC reservation per hardware channel (hart context).
- Each reservation holds a valid bit plus a granule-aligned address.
- Serves SC success checks in the MEM stage; snoops stores so that conflicting writes invalidate reservations; clears on exception flush.
- Sits beside the MEM/WB boundary; replaces the per-core LLbit register.

Parameters:
- NUM_CH, 2, number of channels (1..2**CH_W)
- CH_W, 1, channel index width
- ADDR_W, 32, physical address width
- GRAN_LSB, 2, compare addr[ADDR_W-1:GRAN_LSB] only (reservation granule = 2**GRAN_LSB bytes)
- TIMEOUT, 255, cycles before a reservation expires (only with LLSC_TIMEOUT_EN; must be >= 1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- flush  in  NUM_CH  per-channel exception flush; clears that channel's reservation
- ll_valid  in  1  LL executing this cycle
- ll_ch  in  CH_W  channel issuing the LL
- ll_addr  in  ADDR_W  LL address
- sc_valid  in  1  SC executing this cycle
- sc_ch  in  CH_W  channel issuing the SC
- sc_addr  in  ADDR_W  SC address
- sc_success  out  1  combinational; SC may write memory, rt <= 1
- st_valid  in  1  ordinary store executing this cycle
- st_ch  in  CH_W  channel issuing the store
- st_addr  in  ADDR_W  store address
- llbit_o  out  NUM_CH  registered reservation valid bits

Behaviour:
- Reset (rst=0, asynchronous): all valid bits 0, stored addresses 0, llbit_o=0, timeout counters 0. sc_success=0 while in reset.
- Address match (match(a,b)): a[ADDR_W-1:GRAN_LSB] == b[ADDR_W-1:GRAN_LSB].
- sc_success = sc_valid & valid[sc_ch] & match(sc_addr, resv_addr[sc_ch]) & !flush[sc_ch].
  - Evaluated against pre-edge state; zero-latency, same cycle.
- Invalidating write event (per channel c):
  - st_valid & st_ch!=c & match(st_addr, resv_addr[c]); or
  - sc_success & sc_ch!=c & match(sc_addr, resv_addr[c]).
  - A plain store from the owning channel does NOT clear its own reservation.
- Per-channel next state at rising edge, priority high to low:
  1. flush[c]: valid<=0.
  2. ll_valid & ll_ch==c: valid<=1, resv_addr<=ll_addr. LL wins over a same-cycle invalidating write and over an own SC.
  3. sc_valid & sc_ch==c: valid<=0, regardless of success.
  4. Invalidating write event on c: valid<=0.
  5. Otherwise: hold.
- Channel indices >= NUM_CH on ll_ch/sc_ch/st_ch are ignored: no state change, sc_success=0.
- llbit_o[c] = valid[c]. It updates one cycle after the causing event. No internal bypass; the pipeline forwards if needed.
- ll_valid, sc_valid and st_valid may all be asserted in the same cycle; each is handled independently per the rules above.
- Reset asserted mid-operation clears everything immediately. No partial state survives.

Optional Feature:
- Macro: LLSC_TIMEOUT_EN.
- Defined:
  - Each channel has a counter of width clog2(TIMEOUT+1).
  - The counter loads 0 on LL to that channel and increments each cycle while valid=1.
  - When the counter == TIMEOUT and no higher-priority rule applies, valid<=0 at that edge.
  - The counter holds at 0 while valid=0. flush and reset zero it.
  - A reservation set at edge N is therefore cleared at edge N+TIMEOUT+1.
- Undefined: no counters instantiated; reservations persist until flush, SC, or an invalidating write.

Test Plan:
- Reset release, then LL ch0 addr 0x100, next cycle SC ch0 addr 0x100 -> sc_success=1; llbit_o goes 01 then 00.
- LL ch1 addr 0x200, then store ch0 addr 0x203 (GRAN_LSB=2) -> llbit_o[1] clears next edge; SC ch1 0x200 -> sc_success=0.
- LL ch0 0x300, then store ch0 0x300 (own channel) -> llbit_o[0] stays 1; SC ch0 0x300 -> sc_success=1.
- LL ch0 and LL ch1 both 0x400; SC ch0 0x400 succeeds -> llbit_o[1] cleared the same edge; SC ch1 0x400 -> sc_success=0.
- Same cycle: flush[0]=1 with SC ch0 on a valid matching reservation -> sc_success=0, llbit_o[0]=0. Same cycle: LL ch1 with a store ch0 matching the old address -> llbit_o[1]=1 holding the new address.
- LLSC_TIMEOUT_EN, TIMEOUT=4: LL ch0 at edge N -> llbit_o[0] falls after edge N+5; SC at cycle N+6 -> sc_success=0. Without the macro, still 1 after 1000 cycles.

Source files
------------

// File: rtl/llsc_reservation_unit.sv
// LL/SC reservation tracker: one valid bit plus granule tag per hardware channel.
// Optional reservation expiry is enabled with the LLSC_TIMEOUT_EN macro.
module llsc_reservation_unit #(
   parameter int NUM_CH   = 2,
   parameter int CH_W     = 1,
   parameter int ADDR_W   = 32,
   parameter int GRAN_LSB = 2,
   parameter int TIMEOUT  = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] flush,
   input  logic              ll_valid,
   input  logic [CH_W-1:0]   ll_ch,
   input  logic [ADDR_W-1:0] ll_addr,
   input  logic              sc_valid,
   input  logic [CH_W-1:0]   sc_ch,
   input  logic [ADDR_W-1:0] sc_addr,
   output logic              sc_success,
   input  logic              st_valid,
   input  logic [CH_W-1:0]   st_ch,
   input  logic [ADDR_W-1:0] st_addr,
   output logic [NUM_CH-1:0] llbit_o
);

   localparam int TAG_W = ADDR_W - GRAN_LSB;

   // Only the granule tag takes part in matching, so only the tag is stored.
   logic [TAG_W-1:0] ll_tag;
   logic [TAG_W-1:0] sc_tag;
   logic [TAG_W-1:0] st_tag;
   logic             unused_lsb;

   assign ll_tag     = ll_addr[ADDR_W-1:GRAN_LSB];
   assign sc_tag     = sc_addr[ADDR_W-1:GRAN_LSB];
   assign st_tag     = st_addr[ADDR_W-1:GRAN_LSB];
   assign unused_lsb = ^{ll_addr[GRAN_LSB-1:0], sc_addr[GRAN_LSB-1:0], st_addr[GRAN_LSB-1:0]};

   logic [NUM_CH-1:0] valid;
   logic [TAG_W-1:0]  resv_tag [NUM_CH];
   logic [NUM_CH-1:0] ll_hit;
   logic [NUM_CH-1:0] sc_own;
   logic [NUM_CH-1:0] inval;
   logic [NUM_CH-1:0] expire;
   logic              sc_ok;
   logic              st_in_range;

   // Out-of-range channel indices never match any c, so they are ignored.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, or a latch is inferred.
      sc_ok  = 1'b0;
      ll_hit = '0;
      sc_own = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         ll_hit[c] = ll_valid && (int'(ll_ch) == c);
         sc_own[c] = sc_valid && (int'(sc_ch) == c);
         if (sc_own[c] && valid[c] && !flush[c] && (sc_tag == resv_tag[c])) begin
            sc_ok = 1'b1;
         end
      end
   end

   assign sc_success  = sc_ok & rst;
   assign st_in_range = int'(st_ch) < NUM_CH;

   // A store or successful SC from another channel to the reserved granule kills the reservation.
   always_comb begin
      inval = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         inval[c] = (st_valid && st_in_range && (int'(st_ch) != c) && (st_tag == resv_tag[c])) ||
                    (sc_success && (int'(sc_ch) != c) && (sc_tag == resv_tag[c]));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
         // NOTE: the tag array is reset too, so no stale address survives a reset.
         for (int c = 0; c < NUM_CH; c++) begin
            resv_tag[c] <= '0;
         end
      end else begin
         // NOTE: state updates use non-blocking assignments so every channel sees pre-edge values.
         for (int c = 0; c < NUM_CH; c++) begin
            if (flush[c]) begin
               valid[c] <= 1'b0;
            end else if (ll_hit[c]) begin
               valid[c]    <= 1'b1;
               resv_tag[c] <= ll_tag;
            end else if (sc_own[c] || inval[c] || expire[c]) begin
               valid[c] <= 1'b0;
            end
         end
      end
   end

   assign llbit_o = valid;

`ifdef LLSC_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt [NUM_CH];

   always_comb begin
      expire = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         expire[c] = valid[c] && (cnt[c] == CNT_W'(TIMEOUT));
      end
   end

   // Counter runs only while a reservation is live and restarts on every LL.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            cnt[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (flush[c] || ll_hit[c] || !valid[c] || sc_own[c] || inval[c] || expire[c]) begin
               cnt[c] <= '0;
            end else begin
               cnt[c] <= cnt[c] + 1'b1;
            end
         end
      end
   end
`else
   localparam int unused_timeout = TIMEOUT;

   assign expire = '0;
`endif

endmodule

// File: tb/tb_llsc_reservation_unit.sv
// Directed bench for llsc_reservation_unit: vector table plus reset and expiry sequences.
module tb_llsc_reservation_unit;

   localparam int NUM_CH = 2;
   localparam int CH_W   = 2;
   localparam int ADDR_W = 32;

   logic              clk;
   logic              rst;
   logic [NUM_CH-1:0] flush;
   logic              ll_valid;
   logic [CH_W-1:0]   ll_ch;
   logic [ADDR_W-1:0] ll_addr;
   logic              sc_valid;
   logic [CH_W-1:0]   sc_ch;
   logic [ADDR_W-1:0] sc_addr;
   logic              sc_success;
   logic              st_valid;
   logic [CH_W-1:0]   st_ch;
   logic [ADDR_W-1:0] st_addr;
   logic [NUM_CH-1:0] llbit_o;

   llsc_reservation_unit #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .ADDR_W(ADDR_W), .GRAN_LSB(2), .TIMEOUT(4)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .ll_valid(ll_valid), .ll_ch(ll_ch), .ll_addr(ll_addr),
      .sc_valid(sc_valid), .sc_ch(sc_ch), .sc_addr(sc_addr), .sc_success(sc_success),
      .st_valid(st_valid), .st_ch(st_ch), .st_addr(st_addr),
      .llbit_o(llbit_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string             name;
      logic [NUM_CH-1:0] fl;
      logic              llv;
      logic [CH_W-1:0]   llc;
      logic [ADDR_W-1:0] lla;
      logic              scv;
      logic [CH_W-1:0]   scc;
      logic [ADDR_W-1:0] sca;
      logic              stv;
      logic [CH_W-1:0]   stc;
      logic [ADDR_W-1:0] sta;
      logic              exp_sc;
      logic [NUM_CH-1:0] exp_llbit;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic add(input string n, input logic [1:0] fl,
                      input logic llv, input logic [1:0] llc, input logic [31:0] lla,
                      input logic scv, input logic [1:0] scc, input logic [31:0] sca,
                      input logic stv, input logic [1:0] stc, input logic [31:0] sta,
                      input logic esc, input logic [1:0] ell);
      vec_t v;
      v.name = n; v.fl = fl;
      v.llv = llv; v.llc = llc; v.lla = lla;
      v.scv = scv; v.scc = scc; v.sca = sca;
      v.stv = stv; v.stc = stc; v.sta = sta;
      v.exp_sc = esc; v.exp_llbit = ell;
      vecs.push_back(v);
   endtask

   task automatic idle_inputs();
      flush = '0;
      ll_valid = 1'b0; ll_ch = '0; ll_addr = '0;
      sc_valid = 1'b0; sc_ch = '0; sc_addr = '0;
      st_valid = 1'b0; st_ch = '0; st_addr = '0;
   endtask

   // Drive one cycle of inputs just after an edge; check sc_success before the next edge
   // and llbit_o just after it.
   task automatic apply(input vec_t v);
      flush = v.fl;
      ll_valid = v.llv; ll_ch = v.llc; ll_addr = v.lla;
      sc_valid = v.scv; sc_ch = v.scc; sc_addr = v.sca;
      st_valid = v.stv; st_ch = v.stc; st_addr = v.sta;
      #2;
      check({v.name, " sc_success"}, 32'(sc_success), 32'(v.exp_sc));
      @(posedge clk);
      #1;
      check({v.name, " llbit_o"}, 32'(llbit_o), 32'(v.exp_llbit));
   endtask

   initial begin
      //   name            flush ll v ch addr       sc v ch addr       st v ch addr       sc  llbit
      add("idle",          2'b00, 0, 0, 32'h0,     0, 0, 32'h0,     0, 0, 32'h0,     0, 2'b00);
      add("ll0_100",       2'b00, 1, 0, 32'h100,   0, 0, 32'h0,     0, 0, 32'h0,     0, 2'b01);
      add("sc0_100",       2'b00, 0, 0, 32'h0,     1, 0, 32'h100,   0, 0, 32'h0,     1, 2'b00);
      add("ll1_200",       2'b00, 1, 1, 32'h200,   0, 0, 32'h0,     0, 0, 32'h0,     0, 2'b10);
      add("st0_203",       2'b00, 0, 0, 32'h0,     0, 0, 32'h0,     1, 0, 32'h203,   0, 2'b00);
      add("sc1_200_dead",  2'b00, 0, 0, 32'h0,     1, 1, 32'h200,   0, 0, 32'h0,     0, 2'b00);
      add("ll0_300",       2'b00, 1, 0, 32'h300,   0, 0, 32'h0,     0, 0, 32'h0,     0, 2'b01);
      add("st0_300_own",   2'b00, 0, 0, 32'h0,     0, 0, 32'h0,     1, 0, 32'h300,   0, 2'b01);
      add("sc0_300",       2'b00, 0, 0, 32'h0,     1, 0, 32'h300,   0, 0, 32'h0,     1, 2'b00);
      add("ll0_400",       2'b00, 1, 0, 32'h400,   0, 0, 32'h0,     0, 0, 32'h0,     0, 2'b01);
      add("ll1_400",       2'b00, 1, 1, 32'h400,   0, 0, 32'h0,     0, 0, 32'h0,     0, 2'b11);
      add("sc0_400_kill1", 2'b00, 0, 0, 32'h0,     1, 0, 32'h400,   0, 0, 32'h0,     1, 2'b00);
      add("sc1_400_dead",  2'b00, 0, 0, 32'h0,     1, 1, 32'h400,   0, 0, 32'h0,     0, 2'b00);
      add("ll0_500",       2'b00, 1, 0, 32'h500,   0, 0, 32'h0,     0, 0, 32'h0,     0, 2'b01);
      add("flush0_sc0",    2'b01, 0, 0, 32'h0,     1, 0, 32'h500,   0, 0, 32'h0,     0, 2'b00);
      add("ll1_600",       2'b00, 1, 1, 32'h600,   0, 0, 32'h0,     0, 0, 32'h0,     0, 2'b10);
      add("ll1_700_st600", 2'b00, 1, 1, 32'h700,   0, 0, 32'h0,     1, 0, 32'h600,   0, 2'b10);
      add("sc1_700",       2'b00, 0, 0, 32'h0,     1, 1, 32'h700,   0, 0, 32'h0,     1, 2'b00);
      add("ll0_800",       2'b00, 1, 0, 32'h800,   0, 0, 32'h0,     0, 0, 32'h0,     0, 2'b01);
      add("ll2_ignored",   2'b00, 1, 2, 32'h900,   0, 0, 32'h0,     0, 0, 32'h0,     0, 2'b01);
      add("st3_ignored",   2'b00, 0, 0, 32'h0,     0, 0, 32'h0,     1, 3, 32'h800,   0, 2'b01);
      add("sc2_ignored",   2'b00, 0, 0, 32'h0,     1, 2, 32'h800,   0, 0, 32'h0,     0, 2'b01);
      add("sc0_804_miss",  2'b00, 0, 0, 32'h0,     1, 0, 32'h804,   0, 0, 32'h0,     0, 2'b00);
      add("ll_sc0_a00",    2'b00, 1, 0, 32'ha00,   1, 0, 32'ha00,   0, 0, 32'h0,     0, 2'b01);
      add("ll_b00_sc_a00", 2'b00, 1, 0, 32'hb00,   1, 0, 32'ha00,   0, 0, 32'h0,     1, 2'b01);
      add("sc0_a03_old",   2'b00, 0, 0, 32'h0,     1, 0, 32'ha03,   0, 0, 32'h0,     0, 2'b00);
      add("flush1_ll1",    2'b10, 1, 1, 32'hc00,   0, 0, 32'h0,     0, 0, 32'h0,     0, 2'b00);
      add("ll1_c00_sc0",   2'b00, 1, 1, 32'hc00,   1, 0, 32'hc00,   0, 0, 32'h0,     0, 2'b10);
      add("ll0_st0_c00",   2'b00, 1, 0, 32'hd00,   0, 0, 32'h0,     1, 0, 32'hc00,   0, 2'b01);
      add("sc1_c00_dead",  2'b00, 0, 0, 32'h0,     1, 1, 32'hc00,   0, 0, 32'h0,     0, 2'b01);

      idle_inputs();
      rst = 1'b0;
      #12;
      check("reset llbit_o", 32'(llbit_o), 32'h0);
      check("reset sc_success", 32'(sc_success), 32'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) apply(vecs[i]);

      // Mid-operation reset: ch0 holds 0xD00 here; an SC to it must fail while in reset.
      sc_valid = 1'b1; sc_ch = 2'd0; sc_addr = 32'hd00;
      rst = 1'b0;
      #1;
      check("midreset llbit_o", 32'(llbit_o), 32'h0);
      check("midreset sc_success", 32'(sc_success), 32'h0);
      #2;
      idle_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("postreset llbit_o", 32'(llbit_o), 32'h0);

      // Reservation lifetime: LL at edge N.
      ll_valid = 1'b1; ll_ch = 2'd0; ll_addr = 32'he00;
      @(posedge clk);
      #1;
      idle_inputs();
      check("life edge N", 32'(llbit_o), 32'h1);
`ifdef LLSC_TIMEOUT_EN
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("life edge N+%0d", k), 32'(llbit_o), 32'h1);
      end
      @(posedge clk);
      #1;
      check("life edge N+5 expired", 32'(llbit_o), 32'h0);
      sc_valid = 1'b1; sc_ch = 2'd0; sc_addr = 32'he00;
      #2;
      check("expired sc_success", 32'(sc_success), 32'h0);
`else
      repeat (1000) @(posedge clk);
      #1;
      check("life after 1000", 32'(llbit_o), 32'h1);
      sc_valid = 1'b1; sc_ch = 2'd0; sc_addr = 32'he00;
      #2;
      check("persistent sc_success", 32'(sc_success), 32'h1);
`endif
      @(posedge clk);
      #1;
      idle_inputs();
      check("life final llbit_o", 32'(llbit_o), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
